// File: rtl/ls_req_unit.sv
// ls_req_unit: single-outstanding load/store requester between execute and
// data_mem. Accepts one op, drives the data_mem handshake, waits on ready
// (ignoring the stale ready that can be present on the first request cycle),
// and returns load data through the writeback arbiter. Stores retire without
// writeback. Misaligned/out-of-range ops and request timeouts raise sticky flags.
module ls_req_unit #(
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 15,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_op,
  input  logic [63:0]      in_addr,
  input  logic [63:0]      in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic [1:0]       mem_control,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  input  logic [63:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             mem_arbiter,
  output logic             wb_valid,
  output logic [63:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  input  logic             wb_grant,
  output logic             err_timeout,
  output logic             err_addr,
  output logic [31:0]      ld_count,
  output logic [31:0]      st_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WB   = 2'b10
  } state_t;

  localparam logic [1:0]  OP_ST     = 2'b00;
  localparam logic [1:0]  OP_LD     = 2'b01;
  localparam logic [1:0]  CTRL_IDLE = 2'b11;
  // Last REQ cycle index; the counter holds 0 on the first REQ cycle.
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [60:0] DEPTH_W   = 61'(DEPTH);

  state_t             state_r;
  state_t             state_s;
  logic [7:0]         cnt_r;
  logic [TAG_W-1:0]   tag_r;
  logic               is_load_r;

  logic               mem_op_s;
  logic               accept_s;
  logic               addr_err_s;
  logic               start_s;
  logic               ready_q_s;
  logic               timeout_s;
  logic               grant_s;

  // Handshake qualification: acceptance, address check, qualified ready, timeout.
  always_comb begin
    mem_op_s    = (in_op == OP_ST) || (in_op == OP_LD);
    accept_s    = in_valid && (state_r == S_IDLE) && mem_op_s;
    addr_err_s  = accept_s && ((in_addr[2:0] != 3'b000) || (in_addr[63:3] >= DEPTH_W));
    start_s     = accept_s && !addr_err_s;
    // A ready seen on the first REQ cycle belongs to the previous op.
    ready_q_s   = (state_r == S_REQ) && mem_ready && (cnt_r != 8'd0);
    timeout_s   = (state_r == S_REQ) && !ready_q_s && (cnt_r == TO_LAST);
    grant_s     = (state_r == S_WB) && wb_grant;
    in_ready    = (state_r == S_IDLE);
    mem_arbiter = grant_s;
  end

  // Next-state logic for the IDLE/REQ/WB sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (ready_q_s) begin
          state_s = is_load_r ? S_WB : S_IDLE;
        end else if (timeout_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WB: begin
        if (wb_grant) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WB;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request-side registers: memory command, address, store data, latched op info, timeout counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_control <= CTRL_IDLE;
      mem_addr    <= 64'd0;
      mem_wdata   <= 64'd0;
      tag_r       <= '0;
      is_load_r   <= 1'b0;
      cnt_r       <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            mem_control <= in_op;
            mem_addr    <= {3'b000, in_addr[63:3]};
            mem_wdata   <= in_wdata;
            tag_r       <= in_tag;
            is_load_r   <= (in_op == OP_LD);
            cnt_r       <= 8'd0;
          end
        end
        S_REQ: begin
          cnt_r <= cnt_r + 8'd1;
          if (ready_q_s || timeout_s) begin
            mem_control <= CTRL_IDLE;
          end
        end
        S_WB: begin
          mem_control <= CTRL_IDLE;
        end
        default: begin
          mem_control <= CTRL_IDLE;
        end
      endcase
    end
  end

  // Writeback registers: capture load data on qualified ready, hold until granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= 64'd0;
      wb_tag   <= '0;
    end else begin
      if (ready_q_s && is_load_r) begin
        wb_valid <= 1'b1;
        wb_data  <= mem_rdata;
        wb_tag   <= tag_r;
      end else if (grant_s) begin
        wb_valid <= 1'b0;
      end
    end
  end

  // Completion counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_count    <= 32'd0;
      st_count    <= 32'd0;
      err_timeout <= 1'b0;
      err_addr    <= 1'b0;
    end else begin
      if (ready_q_s && !is_load_r) begin
        st_count <= st_count + 32'd1;
      end
      if (grant_s) begin
        ld_count <= ld_count + 32'd1;
      end
      if (timeout_s) begin
        err_timeout <= 1'b1;
      end
      if (addr_err_s) begin
        err_addr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ls_req_unit.sv
// Bench for ls_req_unit: a minimum-latency data_mem model, directed stimulus
// that pushes expected load results into a queue, and a monitor that pops and
// compares whenever a writeback is granted.
module tb_ls_req_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [4:0]  in_tag;
  logic        in_ready;
  logic [1:0]  mem_control;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        mem_arbiter;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_tag;
  logic        wb_grant;
  logic        err_timeout;
  logic        err_addr;
  logic [31:0] ld_count;
  logic [31:0] st_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  // data_mem model controls
  logic        mem_en;
  logic        force_ready;
  logic        model_ready;
  logic [63:0] model_rdata;
  logic        pre_en;
  logic [9:0]  pre_addr;
  logic [63:0] pre_data;
  logic [63:0] mem_model [0:1023];

  ls_req_unit #(.DEPTH(1024), .TIMEOUT(15), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_tag(in_tag), .in_ready(in_ready),
    .mem_control(mem_control), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_arbiter(mem_arbiter),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag), .wb_grant(wb_grant),
    .err_timeout(err_timeout), .err_addr(err_addr),
    .ld_count(ld_count), .st_count(st_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem: samples a command, answers with a one-cycle ready next cycle.
  always @(posedge clk) begin
    if (pre_en) mem_model[pre_addr] <= pre_data;
    if (!rst_n) begin
      model_ready <= 1'b0;
    end else if (mem_control != 2'b11 && !model_ready && mem_en) begin
      model_ready <= 1'b1;
      if (mem_control == 2'b00) mem_model[mem_addr[9:0]] <= mem_wdata;
      else model_rdata <= mem_model[mem_addr[9:0]];
    end else begin
      model_ready <= 1'b0;
    end
  end

  assign mem_ready = model_ready | force_ready;
  assign mem_rdata = model_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every granted writeback.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_grant) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_data", wb_data, e.data);
        check("wb_tag", {59'd0, wb_tag}, {59'd0, e.tag});
        check("arbiter_on_grant", {63'd0, mem_arbiter}, 64'd1);
      end
    end else if (rst_n && wb_grant && !wb_valid) begin
      check("arbiter_outside_wb", {63'd0, mem_arbiter}, 64'd0);
    end
  end

  task automatic preload(input logic [9:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Presents one op for a single accept edge; returns 1ns into the following cycle (C1).
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] d,
                       input logic [4:0] t);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = d; in_tag = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_wb(input int budget);
    int n = 0;
    @(negedge clk);
    while (wb_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_wb_valid", {63'd0, wb_valid}, 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b11; in_addr = 64'd0; in_wdata = 64'd0;
    in_tag = 5'd0; wb_grant = 1'b0; mem_en = 1'b1; force_ready = 1'b0;
    pre_en = 1'b0; pre_addr = 10'd0; pre_data = 64'd0;
    preload(10'd5, 64'hDEAD_BEEF_0000_0001);
    preload(10'd9, 64'hA5A5_5A5A_0F0F_F0F0);
    @(negedge clk);
    // Reset state
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_mem_control", {62'd0, mem_control}, 64'd3);
    check("rst_mem_arbiter", {63'd0, mem_arbiter}, 64'd0);
    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_errs", {62'd0, err_timeout, err_addr}, 64'd0);
    check("rst_counts", {ld_count, st_count}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Single load with grant tied high: C1 address, C3 writeback, C4 ready.
    wb_grant = 1'b1;
    e.data = 64'hDEAD_BEEF_0000_0001; e.tag = 5'd7; exp_q.push_back(e);
    issue(2'b01, 64'h28, 64'd0, 5'd7);
    @(negedge clk);
    check("t1_mem_addr_c1", mem_addr, 64'd5);
    check("t1_mem_control_c1", {62'd0, mem_control}, 64'd1);
    check("t1_in_ready_c1", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("t1_wb_valid_c2", {63'd0, wb_valid}, 64'd0);
    @(negedge clk);
    check("t1_wb_valid_c3", {63'd0, wb_valid}, 64'd1);
    @(negedge clk);
    check("t1_in_ready_c4", {63'd0, in_ready}, 64'd1);
    check("t1_ld_count", {32'd0, ld_count}, 64'd1);

    // Store then load of the same word.
    issue(2'b00, 64'h40, 64'h1234, 5'd0);
    @(negedge clk);
    check("t2_st_in_ready_c2", {63'd0, in_ready}, 64'd0);
    wait_idle(10);
    check("t2_ctrl_between", {62'd0, mem_control}, 64'd3);
    check("t2_st_count", {32'd0, st_count}, 64'd1);
    e.data = 64'h1234; e.tag = 5'd3; exp_q.push_back(e);
    issue(2'b01, 64'h40, 64'd0, 5'd3);
    wait_idle(10);
    check("t2_ld_count", {32'd0, ld_count}, 64'd2);

    // Delayed grant: writeback held five cycles, arbiter pulses with grant.
    wb_grant = 1'b0;
    e.data = 64'hA5A5_5A5A_0F0F_F0F0; e.tag = 5'h1F; exp_q.push_back(e);
    issue(2'b01, 64'h48, 64'd0, 5'h1F);
    wait_wb(10);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t3_hold_valid", {63'd0, wb_valid}, 64'd1);
      check("t3_hold_data", wb_data, 64'hA5A5_5A5A_0F0F_F0F0);
      check("t3_hold_tag", {59'd0, wb_tag}, 64'h1F);
      check("t3_hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("t3_hold_arbiter", {63'd0, mem_arbiter}, 64'd0);
    end
    @(posedge clk); #1; wb_grant = 1'b1;
    @(negedge clk);
    check("t3_arbiter_grant", {63'd0, mem_arbiter}, 64'd1);
    @(posedge clk); #1; wb_grant = 1'b0;
    @(negedge clk);
    check("t3_arbiter_after", {63'd0, mem_arbiter}, 64'd0);
    check("t3_in_ready_after", {63'd0, in_ready}, 64'd1);
    check("t3_ld_count", {32'd0, ld_count}, 64'd3);

    // Stale ready on the first REQ cycle must not complete the store.
    force_ready = 1'b1;
    issue(2'b00, 64'h50, 64'h77, 5'd0);
    @(negedge clk);
    @(negedge clk);
    check("t4_stale_in_ready_c2", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("t4_in_ready_c3", {63'd0, in_ready}, 64'd1);
    check("t4_st_count", {32'd0, st_count}, 64'd2);
    @(posedge clk); #1; force_ready = 1'b0;

    // Address errors and a non-memory op, grant held high outside WB.
    wb_grant = 1'b1;
    check("t5_err_addr_pre", {63'd0, err_addr}, 64'd0);
    issue(2'b01, 64'h2B, 64'd0, 5'd1);
    @(negedge clk);
    check("t5_err_addr_mis", {63'd0, err_addr}, 64'd1);
    check("t5_ctrl_mis", {62'd0, mem_control}, 64'd3);
    check("t5_in_ready_mis", {63'd0, in_ready}, 64'd1);
    issue(2'b00, 64'h2000, 64'h99, 5'd0);
    @(negedge clk);
    check("t5_ctrl_oor", {62'd0, mem_control}, 64'd3);
    check("t5_in_ready_oor", {63'd0, in_ready}, 64'd1);
    issue(2'b10, 64'h10, 64'h99, 5'd0);
    @(negedge clk);
    check("t5_ctrl_nonmem", {62'd0, mem_control}, 64'd3);
    check("t5_in_ready_nonmem", {63'd0, in_ready}, 64'd1);
    check("t5_counts", {ld_count, st_count}, {32'd3, 32'd2});
    wb_grant = 1'b0;

    // Timeout: no ready for 15 REQ cycles.
    mem_en = 1'b0;
    issue(2'b01, 64'h08, 64'd0, 5'd2);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("t6_req_busy", {63'd0, in_ready}, 64'd0);
      check("t6_no_err_yet", {63'd0, err_timeout}, 64'd0);
    end
    @(negedge clk);
    check("t6_err_timeout", {63'd0, err_timeout}, 64'd1);
    check("t6_ctrl", {62'd0, mem_control}, 64'd3);
    check("t6_in_ready", {63'd0, in_ready}, 64'd1);
    check("t6_no_wb", {63'd0, wb_valid}, 64'd0);
    check("t6_ld_count", {32'd0, ld_count}, 64'd3);
    @(posedge clk); #1; mem_en = 1'b1;

    // Reset while a writeback is pending.
    issue(2'b01, 64'h28, 64'd0, 5'd4);
    wait_wb(10);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("t7_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("t7_counts", {ld_count, st_count}, 64'd0);
    check("t7_in_ready", {63'd0, in_ready}, 64'd1);
    check("t7_ctrl", {62'd0, mem_control}, 64'd3);
    check("t7_errs", {62'd0, err_timeout, err_addr}, 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
